// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM/source types and width defaults
// for the data-RAM arbiter and its priority picker.
package ram_arbiter_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int BUS_WIDTH      = 8;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ArbState;

  typedef enum logic [1:0] {
    SRC_CORE_RD,
    SRC_CORE_WR,
    SRC_HOST
  } ArbSrc;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] lim
  );
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select for the RAM arbiter.
// A starved host beats the core; otherwise core read > core write > host.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             rd_req_i,
  input  logic             wr_req_i,
  input  logic             host_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output ArbSrc            src_o,
  output logic             valid_o
);

  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  logic host_forced;

  assign host_forced = host_req_i & (starve_cnt_i == SMAX);

  // first matching term wins
  always_comb begin
    src_o   = SRC_CORE_RD;
    valid_o = 1'b1;
    priority case (1'b1)
      host_forced: src_o = SRC_HOST;
      rd_req_i:    src_o = SRC_CORE_RD;
      wr_req_i:    src_o = SRC_CORE_WR;
      host_req_i:  src_o = SRC_HOST;
      default:     valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises core and host/debug accesses to one RAM port.
// Optional RAM_ARB_HOST_WP_EN refuses host writes while the core is active.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = BUS_WIDTH,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_rd_en,
  input  logic [ADDR_W-1:0] core_rd_addr,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_rd_ack,
  input  logic              core_wr_en,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_wr_ack,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
);

  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  ArbState           state_q;
  ArbSrc             src_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_ack_q;
  logic              wr_ack_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] host_rdata_q;
  ArbSrc             pick_src;
  logic              pick_vld;
  logic              host_refuse;

  ram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .rd_req_i    (core_rd_en),
    .wr_req_i    (core_wr_en),
    .host_req_i  (host_req),
    .starve_cnt_i(starve_q),
    .src_o       (pick_src),
    .valid_o     (pick_vld)
  );

`ifdef RAM_ARB_HOST_WP_EN
  logic [CNT_W-1:0] idle_q;
  logic             core_act;

  assign core_act = core_rd_en | core_wr_en;

  // cycles since the core last asked, saturating at end of window
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_q <= '1;
    end else if (core_act) begin
      idle_q <= '0;
    end else if (idle_q != '1) begin
      idle_q <= idle_q + CNT_W'(1);
    end
  end

  assign host_refuse = host_we & (core_act | (idle_q != '1));
`else
  assign host_refuse = 1'b0;
`endif

  // consecutive core wins while the host waits
  always_comb begin
    starve_d = starve_q;
    if (!host_req) begin
      starve_d = '0;
    end else if (state_q == IDLE && pick_vld) begin
      if (pick_src == SRC_HOST) starve_d = '0;
      else                      starve_d = sat_inc(starve_q, SMAX);
    end
  end

  // access sequencer: arbitrate, strobe, wait out busy, ack
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      src_q        <= SRC_CORE_RD;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      rd_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      mem_en_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      host_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            src_q <= pick_src;
            unique case (pick_src)
              SRC_CORE_RD: begin
                mem_we_q   <= 1'b0;
                mem_addr_q <= core_rd_addr;
              end
              SRC_CORE_WR: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= core_wr_addr;
                mem_wdata_q <= core_wr_data;
              end
              default: begin
                mem_we_q    <= host_we;
                mem_addr_q  <= host_addr;
                mem_wdata_q <= host_wdata;
              end
            endcase
            if (pick_src == SRC_HOST && host_refuse) begin
              host_rdata_q <= DATA_W'(8'hFF);
              host_ack_q   <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_en_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (!mem_busy) begin
            if (!mem_we_q) begin
              if (src_q == SRC_HOST) host_rdata_q <= mem_rdata;
              else                   rd_data_q    <= mem_rdata;
            end
            rd_ack_q   <= (src_q == SRC_CORE_RD);
            wr_ack_q   <= (src_q == SRC_CORE_WR);
            host_ack_q <= (src_q == SRC_HOST);
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rd_ack  = rd_ack_q;
  assign core_wr_ack  = wr_ack_q;
  assign host_ack     = host_ack_q;
  assign core_rd_data = rd_data_q;
  assign host_rdata   = host_rdata_q;
  assign core_stall   = (core_rd_en & ~rd_ack_q)
                      | (core_wr_en & ~wr_ack_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random core/host traffic against a transaction-level
// model of the arbitration, latency, data and reset rules.
module tb_ram_arbiter;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int SMAX   = 4;
  localparam int NCYC   = 4000;
  localparam int RST_AT = 2000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          core_rd_en;
  logic [AW-1:0] core_rd_addr;
  logic [DW-1:0] core_rd_data;
  logic          core_rd_ack;
  logic          core_wr_en;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data;
  logic          core_wr_ack;
  logic          core_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;

  ram_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .core_rd_en  (core_rd_en),
    .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data),
    .core_rd_ack (core_rd_ack),
    .core_wr_en  (core_wr_en),
    .core_wr_addr(core_wr_addr),
    .core_wr_data(core_wr_data),
    .core_wr_ack (core_wr_ack),
    .core_stall  (core_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_busy    (mem_busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rd_hold;

  bit            t_act;
  bit            t_we;
  bit            t_ref;
  int            t_src;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [DW-1:0] t_rdata;
  int            en_at;
  int            ack_at;
  int            starve;
  int            last_core;

  bit rd_fin, wr_fin, h_fin;
  int rd_gap, wr_gap, h_gap;
  bit want_rst;
  bit exp_en, exp_ack, e_rd, e_wr, e_h;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " mem_en"},     32'(mem_en),       32'(0));
    check({tag, " mem_we"},     32'(mem_we),       32'(0));
    check({tag, " mem_addr"},   32'(mem_addr),     32'(0));
    check({tag, " mem_wdata"},  32'(mem_wdata),    32'(0));
    check({tag, " rd_ack"},     32'(core_rd_ack),  32'(0));
    check({tag, " wr_ack"},     32'(core_wr_ack),  32'(0));
    check({tag, " host_ack"},   32'(host_ack),     32'(0));
    check({tag, " rd_data"},    32'(core_rd_data), 32'(0));
    check({tag, " host_rdata"}, 32'(host_rdata),   32'(0));
    check({tag, " stall"},      32'(core_stall),
          32'(core_rd_en | core_wr_en));
  endtask

  // arbitration rules applied to this cycle's requests
  task automatic model_step(input bit can_grant);
    bit rd, wr, hr;
    int src;
    rd = core_rd_en;
    wr = core_wr_en;
    hr = host_req;
    if (rd | wr) last_core = cyc;
    if (can_grant && !t_act && (rd | wr | hr)) begin
      if (hr && starve >= SMAX) src = 2;
      else if (rd)              src = 0;
      else if (wr)              src = 1;
      else                      src = 2;
      if (src == 2)                 starve = 0;
      else if (hr && starve < SMAX) starve++;
      t_act  = 1'b1;
      t_src  = src;
      t_ref  = 1'b0;
      en_at  = cyc + 1;
      ack_at = -1;
      if (src == 0) begin
        t_we    = 1'b0;
        t_addr  = core_rd_addr;
        t_rdata = ref_mem[core_rd_addr];
      end else if (src == 1) begin
        t_we    = 1'b1;
        t_addr  = core_wr_addr;
        t_wdata = core_wr_data;
        ref_mem[core_wr_addr] = core_wr_data;
      end else begin
        t_we    = host_we;
        t_addr  = host_addr;
        t_wdata = host_wdata;
`ifdef RAM_ARB_HOST_WP_EN
        t_ref = host_we && (cyc - last_core < 16);
`endif
        if (t_ref) begin
          t_rdata = 8'hFF;
          en_at   = -1;
          ack_at  = cyc + 1;
        end else if (host_we) begin
          ref_mem[host_addr] = host_wdata;
        end else begin
          t_rdata = ref_mem[host_addr];
        end
      end
    end
    if (!hr) starve = 0;
  endtask

  // requesters: hold until ack, sometimes back-to-back, sometimes drop
  task automatic drive_agents();
    bit own;
    own = t_act && t_src == 0;
    if (core_rd_en) begin
      if (rd_fin) begin
        if ($urandom_range(0, 1) == 1) begin
          core_rd_addr = AW'($urandom_range(0, 15));
        end else begin
          core_rd_en = 1'b0;
          rd_gap     = $urandom_range(0, 3);
        end
      end else if (own) begin
        if ($urandom_range(0, 3) == 0) core_rd_addr = AW'($urandom);
        if ($urandom_range(0, 15) == 0) core_rd_en = 1'b0;
      end else if ($urandom_range(0, 31) == 0) begin
        core_rd_en = 1'b0;
      end
    end else if (rd_gap > 0) begin
      rd_gap--;
    end else if (!own && $urandom_range(0, 1) == 1) begin
      core_rd_en   = 1'b1;
      core_rd_addr = AW'($urandom_range(0, 15));
    end

    own = t_act && t_src == 1;
    if (core_wr_en) begin
      if (wr_fin) begin
        core_wr_en = 1'b0;
        wr_gap     = $urandom_range(0, 4);
      end else if (own) begin
        if ($urandom_range(0, 3) == 0) core_wr_addr = AW'($urandom);
        if ($urandom_range(0, 3) == 0) core_wr_data = DW'($urandom);
        if ($urandom_range(0, 15) == 0) core_wr_en = 1'b0;
      end
    end else if (wr_gap > 0) begin
      wr_gap--;
    end else if (!own && $urandom_range(0, 2) == 0) begin
      core_wr_en   = 1'b1;
      core_wr_addr = AW'($urandom_range(0, 15));
      core_wr_data = DW'($urandom);
    end

    own = t_act && t_src == 2;
    if (host_req) begin
      if (h_fin) begin
        host_req = 1'b0;
        h_gap    = $urandom_range(0, 6);
      end else if (own) begin
        if ($urandom_range(0, 3) == 0) host_addr  = AW'($urandom);
        if ($urandom_range(0, 3) == 0) host_wdata = DW'($urandom);
        if ($urandom_range(0, 3) == 0) host_we    = ~host_we;
      end else if ($urandom_range(0, 63) == 0) begin
        host_req = 1'b0;
      end
    end else if (h_gap > 0) begin
      h_gap--;
    end else if (!own && $urandom_range(0, 2) == 0) begin
      host_req   = 1'b1;
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = AW'($urandom_range(0, 15));
      host_wdata = DW'($urandom);
    end
  endtask

  // async reset while an access waits on a busy RAM
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    cyc++;
    want_rst  = 1'b0;
    t_act     = 1'b0;
    en_at     = -1;
    ack_at    = -1;
    starve    = 0;
    last_core = -100;
    rd_fin    = 1'b0;
    wr_fin    = 1'b0;
    h_fin     = 1'b0;
    model_step(1'b1);
  endtask

  initial begin
    rstn         = 1'b0;
    core_rd_en   = 1'b0;
    core_rd_addr = '0;
    core_wr_en   = 1'b0;
    core_wr_addr = '0;
    core_wr_data = '0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    mem_busy     = 1'b0;
    mem_rdata    = '0;
    rd_hold      = '0;
    t_act        = 1'b0;
    t_we         = 1'b0;
    t_ref        = 1'b0;
    t_src        = 0;
    t_addr       = '0;
    t_wdata      = '0;
    t_rdata      = '0;
    en_at        = -1;
    ack_at       = -1;
    starve       = 0;
    last_core    = -100;
    rd_fin       = 1'b0;
    wr_fin       = 1'b0;
    h_fin        = 1'b0;
    rd_gap       = 0;
    wr_gap       = 0;
    h_gap        = 0;
    want_rst     = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ram[a]     = DW'($urandom);
      ref_mem[a] = ram[a];
    end
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_en = t_act && (cyc == en_at);
      check("mem_en", 32'(mem_en), 32'(exp_en));
      if (exp_en) begin
        check("mem_we", 32'(mem_we), 32'(t_we));
        check("mem_addr", 32'(mem_addr), 32'(t_addr));
        if (t_we) check("mem_wdata", 32'(mem_wdata), 32'(t_wdata));
      end
      exp_ack = t_act && (cyc == ack_at);
      e_rd    = exp_ack && t_src == 0;
      e_wr    = exp_ack && t_src == 1;
      e_h     = exp_ack && t_src == 2;
      check("core_rd_ack", 32'(core_rd_ack), 32'(e_rd));
      check("core_wr_ack", 32'(core_wr_ack), 32'(e_wr));
      check("host_ack", 32'(host_ack), 32'(e_h));
      if (e_rd) check("core_rd_data", 32'(core_rd_data), 32'(t_rdata));
      if (e_h && (!t_we || t_ref))
        check("host_rdata", 32'(host_rdata), 32'(t_rdata));
      if (exp_ack) t_act = 1'b0;

      drive_agents();

      mem_busy  = want_rst ? 1'b1 : ($urandom_range(0, 3) == 0);
      mem_rdata = mem_busy ? DW'($urandom) : rd_hold;
      if (mem_en) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        rd_hold = ram[mem_addr];
      end
      if (t_act && en_at >= 0 && cyc > en_at && ack_at < 0 && !mem_busy)
        ack_at = cyc + 1;

      model_step(!exp_ack);

      #1;
      check("core_stall", 32'(core_stall),
            32'((core_rd_en && !e_rd) || (core_wr_en && !e_wr)));
      rd_fin = core_rd_ack;
      wr_fin = core_wr_ack;
      h_fin  = host_ack;

      if (cyc == RST_AT) want_rst = 1'b1;
      if (want_rst && t_act && en_at >= 0 && cyc > en_at && ack_at < 0)
        do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
